mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Sole owner of the byte-wide RAM/IO port. Arbitrates instruction-fetch reads against SLB loads/stores.
//  Splits each access into byte beats; load data returned raw, little-endian, zero-padded (SLB extends).
//  Sits between insfetch/SLB and the external RAM.
// PARAMETERS
//  ADDR_W   32            address width
//  IO_BASE  32'h0003_0000 addresses with addr[17:16]==2'b11 are IO; IO writes stall on io_buffer_full
// PORTS
//  clk                         in   1   clock, all state on posedge
//  rst_n                       in   1   asynchronous, active-low reset
//  rdy                         in   1   0 = freeze all state, mem_wr forced 0
//  Clear_flag                  in   1   mispredict flush
//  insfetch_req                in   1   level; held until insfetch_ok or Clear_flag
//  insfetch_addr               in   32  fetch address, stable while insfetch_req
//  insfetch_ok                 out  1   1-cycle pulse, insfetch_data valid
//  insfetch_data               out  32  fetched word
//  SLB_to_memctrl_needchange   in   1   1-cycle load request pulse
//  SLB_to_memctrl_needchange2  in   1   1-cycle store request pulse
//  SLB_to_memctrl_ordertype    in   INST_TYPE_WIDTH  LB/LH/LW/LBU/LHU/SB/SH/SW
//  SLB_to_memctrl_vj           in   32  base; address = vj + A (mod 2^32)
//  SLB_to_memctrl_vk           in   32  store data, low bytes used
//  SLB_to_memctrl_A            in   32  immediate offset
//  memctrl_data_ok             out  1   1-cycle pulse: SLB op complete
//  memctrl_data_ans            out  32  load bytes, zero above size; 0 for stores
//  mem_din                     in   8   RAM read byte, 1-cycle sync-read latency
//  mem_dout                    out  8   RAM write byte
//  mem_a                       out  32  RAM byte address
//  mem_wr                      out  1   1 = write
//  io_buffer_full              in   1   IO sink full
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; pending-SLB slot empty.
//  States: IDLE, RD, WR. Beat counter cnt[2:0]; size N=1/2/4 from ordertype, fetch always N=4.
//  SLB request pulses latched into 1-deep pending slot (op, addr, data, N) if not accepted that edge.
//  SLB never issues a 2nd request before data_ok, so slot never overflows.
//  IDLE accept priority: pending/incoming SLB > fetch. No preemption once in RD/WR.
//  RD, accept edge E0: mem_a<=addr, mem_wr<=0. Edge Ek (k<N): mem_a<=addr+k.
//   Byte k captured from mem_din at E(k+2) into bits [8k+7:8k].
//  RD, last byte at E(N+1): ok pulse + data registered (includes live mem_din); state<=IDLE.
//   The ok pulse is memctrl_data_ok or insfetch_ok. Load latency N+1 edges.
//  WR, E0: mem_a<=addr, mem_dout<=vk[7:0], mem_wr<=1. Ek: byte k at addr+k.
//  WR, E(N): mem_wr<=0, memctrl_data_ok<=1, state<=IDLE.
//  IO write with io_buffer_full=1: no beat advance, mem_wr=0 that cycle, resume when clear.
//  New request may be accepted on the edge after ok pulse (1 idle cycle between ops).
//  Clear_flag, in-flight RD (fetch or load): abort to IDLE; no ok pulse, incl. the completing edge.
//  Clear_flag also drops a pending load; the aborted access issues no further RAM beats.
//  Clear_flag with store in flight or pending: the store is committed; it completes normally.
//  Clear_flag with store pulse arriving the same edge: the store is still accepted.
//  rdy=0 mid-op: hold all regs incl. cnt, mem_wr=0; resume at same beat.
//  Address arithmetic wraps mod 2^32. Unaligned accesses are legal (byte beats).
// STRUCTURE
//  Shared info.v: INST_TYPE_WIDTH, DATA_WIDTH, ordertype codes LB..SW, IO_BASE.
//  Sub-module mem_size_decode: ordertype -> {is_store, nbytes[2:0]}. Everything else in mem_ctrl.
// TESTING
//  1. LW vj=0x100,A=4; RAM[0x104..7]=11 22 33 44 -> data_ok 5 edges later, ans=0x44332211.
//  2. SH vk=0xABCD at 0x200 -> mem_wr beats CD@0x200, AB@0x201; data_ok after 2 edges; RAM updated.
//  3. Fetch 0x0 req and LB 0x10 pulse same cycle -> LB served first (ans=0x000000xx);
//     fetch starts next idle edge, insfetch_ok with the word at 0x0.
//  4. Fetch in flight, Clear_flag at beat 2 -> no insfetch_ok; mem_a stops advancing; IDLE next cycle.
//  5. SW to 0x30000, io_buffer_full held 3 cycles after beat 1 -> beats 0,1 then stall 3 cycles.
//     Then beats 2,3; data_ok once.
//  6. rst_n low mid-WR -> outputs 0 immediately; rdy=0 2 cycles mid-LW -> ok delayed exactly 2.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: widths, load/store order codes,
// the IO window base and the controller state encoding.
package mem_ctrl_pkg;

  localparam int INST_TYPE_WIDTH = 4;
  localparam int DATA_WIDTH      = 32;

  localparam logic [31:0] IO_BASE_ADDR = 32'h0003_0000;

  localparam logic [INST_TYPE_WIDTH-1:0] OP_LB  = 4'd0;
  localparam logic [INST_TYPE_WIDTH-1:0] OP_LH  = 4'd1;
  localparam logic [INST_TYPE_WIDTH-1:0] OP_LW  = 4'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] OP_LBU = 4'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] OP_LHU = 4'd4;
  localparam logic [INST_TYPE_WIDTH-1:0] OP_SB  = 4'd5;
  localparam logic [INST_TYPE_WIDTH-1:0] OP_SH  = 4'd6;
  localparam logic [INST_TYPE_WIDTH-1:0] OP_SW  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_size_decode.sv
// Maps an SLB order type to its direction and byte count. Sign/zero extension
// is left to the SLB, so signed and unsigned loads decode identically.
module mem_size_decode
  import mem_ctrl_pkg::*;
(
  input  logic [INST_TYPE_WIDTH-1:0] i_ordertype,
  output logic                       o_is_store,
  output logic [2:0]                 o_nbytes
);

  always_comb begin
    o_is_store = 1'b0;
    o_nbytes   = 3'd4;
    case (i_ordertype)
      OP_LB, OP_LBU: o_nbytes = 3'd1;
      OP_LH, OP_LHU: o_nbytes = 3'd2;
      OP_LW:         o_nbytes = 3'd4;
      OP_SB:         begin o_is_store = 1'b1; o_nbytes = 3'd1; end
      OP_SH:         begin o_is_store = 1'b1; o_nbytes = 3'd2; end
      OP_SW:         begin o_is_store = 1'b1; o_nbytes = 3'd4; end
      default:       o_nbytes = 3'd4;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO port owner: arbitrates instruction fetch against SLB loads/stores
// and serialises every access into little-endian byte beats.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] IO_BASE = IO_BASE_ADDR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       Clear_flag,
  input  logic                       insfetch_req,
  input  logic [ADDR_W-1:0]          insfetch_addr,
  output logic                       insfetch_ok,
  output logic [DATA_WIDTH-1:0]      insfetch_data,
  input  logic                       SLB_to_memctrl_needchange,
  input  logic                       SLB_to_memctrl_needchange2,
  input  logic [INST_TYPE_WIDTH-1:0] SLB_to_memctrl_ordertype,
  input  logic [31:0]                SLB_to_memctrl_vj,
  input  logic [31:0]                SLB_to_memctrl_vk,
  input  logic [31:0]                SLB_to_memctrl_A,
  output logic                       memctrl_data_ok,
  output logic [DATA_WIDTH-1:0]      memctrl_data_ans,
  input  logic [7:0]                 mem_din,
  output logic [7:0]                 mem_dout,
  output logic [ADDR_W-1:0]          mem_a,
  output logic                       mem_wr,
  input  logic                       io_buffer_full,
  output logic [1:0]                 o_dbg_state
);

  // Handshake: SLB requests are single-cycle pulses that are always captured (directly
  // or into the pending slot); fetch is a level request held until insfetch_ok or Clear_flag.
  state_t                r_state;
  logic [2:0]            r_cnt, r_n;
  logic [ADDR_W-1:0]     r_addr, r_mem_a;
  logic [31:0]           r_wdata, r_buf;
  logic                  r_is_fetch, r_is_io;
  logic [7:0]            r_mem_dout;
  logic                  r_mem_wr, r_ifok, r_dok;
  logic [31:0]           r_ifdata, r_dans;
  logic                  r_pend_valid, r_pend_store;
  logic [ADDR_W-1:0]     r_pend_addr;
  logic [31:0]           r_pend_data;
  logic [2:0]            r_pend_n;

  logic                  w_is_store;
  logic [2:0]            w_nbytes;
  logic [31:0]           w_inc_sum;
  logic                  w_inc_req, w_inc_live, w_pend_live, w_idle, w_take_slot;
  logic                  w_go, w_go_store, w_go_fetch, w_go_io;
  logic [ADDR_W-1:0]     w_go_addr;
  logic [31:0]           w_go_data, w_rd_word;
  logic [2:0]            w_go_n;

  mem_size_decode u_size_decode (
    .i_ordertype (SLB_to_memctrl_ordertype),
    .o_is_store  (w_is_store),
    .o_nbytes    (w_nbytes)
  );

  assign w_inc_sum = SLB_to_memctrl_vj + SLB_to_memctrl_A;
  assign w_inc_req = SLB_to_memctrl_needchange | SLB_to_memctrl_needchange2;

  // A flush kills loads (pending or arriving) but never a store.
  always_comb begin
    w_pend_live = r_pend_valid && (r_pend_store || !Clear_flag);
    w_inc_live  = w_inc_req && (w_is_store || !Clear_flag);
    w_idle      = (r_state == ST_IDLE);
    w_go        = w_idle && (w_pend_live || w_inc_live || (insfetch_req && !Clear_flag));
    w_take_slot = w_inc_live && !(w_idle && !w_pend_live);
    w_go_store  = 1'b0;
    w_go_fetch  = 1'b1;
    w_go_addr   = insfetch_addr;
    w_go_data   = 32'd0;
    w_go_n      = 3'd4;
    if (w_pend_live) begin
      w_go_store = r_pend_store;
      w_go_fetch = 1'b0;
      w_go_addr  = r_pend_addr;
      w_go_data  = r_pend_data;
      w_go_n     = r_pend_n;
    end else if (w_inc_live) begin
      w_go_store = w_is_store;
      w_go_fetch = 1'b0;
      w_go_addr  = w_inc_sum[ADDR_W-1:0];
      w_go_data  = SLB_to_memctrl_vk;
      w_go_n     = w_nbytes;
    end
    w_go_io = (w_go_addr[17:16] == IO_BASE[17:16]);
  end

  // The final byte is taken straight from mem_din on the completing edge.
  always_comb begin
    w_rd_word = r_buf;
    case (r_n)
      3'd1:    w_rd_word[7:0]   = mem_din;
      3'd2:    w_rd_word[15:8]  = mem_din;
      default: w_rd_word[31:24] = mem_din;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_n          <= 3'd0;
      r_addr       <= '0;
      r_mem_a      <= '0;
      r_wdata      <= 32'd0;
      r_buf        <= 32'd0;
      r_is_fetch   <= 1'b0;
      r_is_io      <= 1'b0;
      r_mem_dout   <= 8'd0;
      r_mem_wr     <= 1'b0;
      r_ifok       <= 1'b0;
      r_dok        <= 1'b0;
      r_ifdata     <= 32'd0;
      r_dans       <= 32'd0;
      r_pend_valid <= 1'b0;
      r_pend_store <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= 32'd0;
      r_pend_n     <= 3'd0;
    end else if (rdy) begin
      r_ifok <= 1'b0;
      r_dok  <= 1'b0;
      if (Clear_flag && !r_pend_store) r_pend_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_go) begin
          if (w_pend_live) r_pend_valid <= 1'b0;
          r_addr     <= w_go_addr;
          r_wdata    <= w_go_data;
          r_n        <= w_go_n;
          r_is_fetch <= w_go_fetch;
          r_is_io    <= w_go_io;
          r_buf      <= 32'd0;
          r_mem_a    <= w_go_addr;
          if (!w_go_store) begin
            r_state  <= ST_RD;
            r_mem_wr <= 1'b0;
            r_cnt    <= 3'd1;
          end else if (w_go_io && io_buffer_full) begin
            r_state  <= ST_WR;
            r_mem_wr <= 1'b0;
            r_cnt    <= 3'd0;
          end else begin
            r_state    <= ST_WR;
            r_mem_dout <= w_go_data[7:0];
            r_mem_wr   <= 1'b1;
            r_cnt      <= 3'd1;
          end
        end
        ST_RD: begin
          if (Clear_flag) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt < r_n) r_mem_a <= r_addr + ADDR_W'(r_cnt);
            // cnt k (2..N) lands byte k-2, issued two edges earlier.
            if (r_cnt >= 3'd2 && r_cnt <= r_n)
              r_buf[{r_cnt[1:0] - 2'd2, 3'b000} +: 8] <= mem_din;
            if (r_cnt == r_n + 3'd1) begin
              r_state <= ST_IDLE;
              if (r_is_fetch) begin
                r_ifok   <= 1'b1;
                r_ifdata <= w_rd_word;
              end else begin
                r_dok  <= 1'b1;
                r_dans <= w_rd_word;
              end
            end
          end
        end
        ST_WR: begin
          if (r_cnt == r_n) begin
            r_mem_wr <= 1'b0;
            r_dok    <= 1'b1;
            r_dans   <= 32'd0;
            r_state  <= ST_IDLE;
          end else if (r_is_io && io_buffer_full) begin
            r_mem_wr <= 1'b0;
          end else begin
            r_mem_a    <= r_addr + ADDR_W'(r_cnt);
            r_mem_dout <= r_wdata[{r_cnt[1:0], 3'b000} +: 8];
            r_mem_wr   <= 1'b1;
            r_cnt      <= r_cnt + 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_take_slot) begin
        r_pend_valid <= 1'b1;
        r_pend_store <= w_is_store;
        r_pend_addr  <= w_inc_sum[ADDR_W-1:0];
        r_pend_data  <= SLB_to_memctrl_vk;
        r_pend_n     <= w_nbytes;
      end
    end
  end

  assign insfetch_ok      = r_ifok;
  assign insfetch_data    = r_ifdata;
  assign memctrl_data_ok  = r_dok;
  assign memctrl_data_ans = r_dans;
  assign mem_dout         = r_mem_dout;
  assign mem_a            = r_mem_a;
  assign mem_wr           = r_mem_wr & rdy;
  assign o_dbg_state      = r_state;

endmodule
